// File: rtl/control_pkg.sv
// ============================================================================
// Module  : control_pkg
// Purpose : Shared control-word bit positions, instruction field encodings and
//           sequencer state codes for control_sequencer and instr_decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package control_pkg;

    localparam int c_ctrl_w = 14;

    localparam int c_b_load_ir    = 13;
    localparam int c_b_load_pc    = 12;
    localparam int c_b_load_a     = 11;
    localparam int c_b_load_b     = 10;
    localparam int c_b_load_x     = 9;
    localparam int c_b_load_q     = 8;
    localparam int c_b_load_m     = 7;
    localparam int c_b_assert_rom = 6;
    localparam int c_b_assert_ram = 5;
    localparam int c_b_assert_a   = 4;
    localparam int c_b_assert_x   = 3;
    localparam int c_b_assert_alu = 2;
    localparam int c_b_do_sub     = 1;
    localparam int c_b_inc_pc     = 0;

    localparam logic [2:0] c_dst_a    = 3'd0;
    localparam logic [2:0] c_dst_b    = 3'd1;
    localparam logic [2:0] c_dst_x    = 3'd2;
    localparam logic [2:0] c_dst_q    = 3'd3;
    localparam logic [2:0] c_dst_pc   = 3'd4;
    localparam logic [2:0] c_dst_pcz  = 3'd5;
    localparam logic [2:0] c_dst_m    = 3'd6;
    localparam logic [2:0] c_dst_halt = 3'd7;

    localparam logic [1:0] c_src_imm = 2'd0;
    localparam logic [1:0] c_src_a   = 2'd1;
    localparam logic [1:0] c_src_x   = 2'd2;
    localparam logic [1:0] c_src_alu = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t c_st_fetch = 2'd0;
    localparam state_t c_st_exec  = 2'd1;
    localparam state_t c_st_halt  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
// Module  : instr_decode
// Purpose : Combinational map from (state, instruction bits [7:2], zero flag)
//           to the 14-bit control word registered by control_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decode
    import control_pkg::*;
(
    input  state_t               i_state,
    input  logic [5:0]           i_op,
    input  logic                 i_zero,
    output logic [c_ctrl_w-1:0]  o_ctrl
);

    logic [2:0] w_dest;
    logic [1:0] w_src;
    logic       w_sub;

    assign w_dest = i_op[5:3];
    assign w_src  = i_op[2:1];
    assign w_sub  = i_op[0];

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            c_st_fetch: begin
                o_ctrl[c_b_load_ir]    = 1'b1;
                o_ctrl[c_b_assert_rom] = 1'b1;
                o_ctrl[c_b_inc_pc]     = 1'b1;
            end
            c_st_exec: begin
                // HALT issues nothing: no load, and nobody drives the bus
                if (w_dest != c_dst_halt) begin
                    case (w_src)
                        c_src_imm: begin
                            o_ctrl[c_b_assert_rom] = 1'b1;
                            o_ctrl[c_b_inc_pc]     = 1'b1;
                        end
                        c_src_a:   o_ctrl[c_b_assert_a] = 1'b1;
                        c_src_x:   o_ctrl[c_b_assert_x] = 1'b1;
                        default: begin
                            o_ctrl[c_b_assert_alu] = 1'b1;
                            o_ctrl[c_b_do_sub]     = w_sub;
                        end
                    endcase
                    case (w_dest)
                        c_dst_a:   o_ctrl[c_b_load_a]  = 1'b1;
                        c_dst_b:   o_ctrl[c_b_load_b]  = 1'b1;
                        c_dst_x:   o_ctrl[c_b_load_x]  = 1'b1;
                        c_dst_q:   o_ctrl[c_b_load_q]  = 1'b1;
                        c_dst_pc:  o_ctrl[c_b_load_pc] = 1'b1;
                        c_dst_pcz: o_ctrl[c_b_load_pc] = i_zero;
                        default:   o_ctrl[c_b_load_m]  = 1'b1;
                    endcase
                end
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module  : control_sequencer
// Purpose : FETCH/EXEC/HALT microsequencer with registered control word.
// Config  : define SEQUENCER_STALL_EN to add the 'run' stall input.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import control_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetB,
`ifdef SEQUENCER_STALL_EN
    input  logic                 run,
`endif
    input  logic [7:0]           dbus,
    input  logic                 zero,
    output logic [c_ctrl_w-1:0]  controlBits,
    output logic [7:0]           ir,
    output logic [7:0]           icount,
    output logic                 halted
);

    state_t               r_state;
    logic [7:0]           r_ir;
    logic [7:0]           r_icount;
    logic                 r_halted;
    logic [c_ctrl_w-1:0]  r_ctrl;
    logic                 r_zero;
    logic                 r_active;

    logic                 w_run;
    logic                 w_fetching;
    state_t               w_state_nxt;
    state_t               w_dec_state;
    logic [5:0]           w_dec_op;
    logic                 w_dec_zero;
    logic [c_ctrl_w-1:0]  w_dec_ctrl;

`ifdef SEQUENCER_STALL_EN
    assign w_run = run;
`else
    assign w_run = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fetch: w_state_nxt = c_st_exec;
            c_st_exec:  w_state_nxt = (r_ir[7:5] == c_dst_halt) ? c_st_halt : c_st_fetch;
            default:    w_state_nxt = r_state;
        endcase
    end

    // r_active low means the current word (0) is not the state's word: after
    // reset or a stall the state is held and its word is (re)issued first.
    assign w_fetching  = r_active && (r_state == c_st_fetch);
    assign w_dec_state = r_active ? w_state_nxt : r_state;
    assign w_dec_op    = w_fetching ? dbus[7:2] : r_ir[7:2];
    assign w_dec_zero  = w_fetching ? zero : r_zero;

    instr_decode u_decode (
        .i_state (w_dec_state),
        .i_op    (w_dec_op),
        .i_zero  (w_dec_zero),
        .o_ctrl  (w_dec_ctrl)
    );

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_state  <= c_st_fetch;
            r_ir     <= '0;
            r_icount <= '0;
            r_halted <= 1'b0;
            r_ctrl   <= '0;
            r_zero   <= 1'b0;
            r_active <= 1'b0;
        end else if (!w_run) begin
            r_ctrl   <= '0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            r_ctrl   <= w_dec_ctrl;
            r_active <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_dec_ctrl;
            if (r_state == c_st_fetch) begin
                r_ir   <= dbus;
                r_zero <= zero;
            end
            if (r_state == c_st_exec) begin
                r_icount <= r_icount + 8'd1;
                if (r_ir[7:5] == c_dst_halt)
                    r_halted <= 1'b1;
            end
        end
    end

    assign controlBits = r_ctrl;
    assign ir          = r_ir;
    assign icount      = r_icount;
    assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module  : tb_control_sequencer
// Purpose : Self-checking bench for control_sequencer against an instruction-
//           level reference model. Define SEQUENCER_STALL_EN for the stall test.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic        clk;
    logic        resetB;
    logic        run;
    logic [7:0]  dbus;
    logic        zero;
    logic [13:0] controlBits;
    logic [7:0]  ir;
    logic [7:0]  icount;
    logic        halted;

    int n_checks;
    int n_errors;
    int exp_icount;

    localparam logic [31:0] c_fetch_word = 32'h2041;

    control_sequencer dut (
        .clk         (clk),
        .resetB      (resetB),
`ifdef SEQUENCER_STALL_EN
        .run         (run),
`endif
        .dbus        (dbus),
        .zero        (zero),
        .controlBits (controlBits),
        .ir          (ir),
        .icount      (icount),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: EXEC word = destination load bit OR source drive bits.
    function automatic logic [31:0] model_word(input logic [7:0] instr, input logic z);
        int          load_pos[7] = '{11, 10, 9, 8, 12, 12, 7};
        int          dest = int'(instr[7:5]);
        int          src  = int'(instr[4:3]);
        logic [31:0] w    = 0;
        if (dest == 7) return 0;
        if (dest != 5 || z) w = w | (32'd1 << load_pos[dest]);
        if (src == 0)      w = w | 32'h41;
        else if (src == 1) w = w | 32'h10;
        else if (src == 2) w = w | 32'h08;
        else               w = w | 32'h04 | (instr[2] ? 32'h2 : 32'h0);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the FETCH word visible; returns with the next FETCH word (or HALT) visible.
    task automatic run_instr(input logic [7:0] instr, input logic z);
        check_value("fetch_word", 32'(controlBits), c_fetch_word);
        dbus = instr;
        zero = z;
        tick();
        check_value("exec_word", 32'(controlBits), model_word(instr, z));
        check_value("ir", 32'(ir), 32'(instr));
        dbus = 8'($urandom);
        zero = 1'($urandom);
        tick();
        exp_icount = (exp_icount + 1) % 256;
        check_value("icount", 32'(icount), 32'(exp_icount));
        check_value("halted", 32'(halted), (instr[7:5] == 3'd7) ? 32'd1 : 32'd0);
        if (instr[7:5] == 3'd7)
            check_value("halt_word", 32'(controlBits), 32'd0);
    endtask

    function automatic logic [7:0] rand_instr();
        logic [7:0] v = 8'($urandom);
        if (v[7:5] == 3'd7) v[7:5] = 3'($urandom_range(0, 6));
        return v;
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_icount = 0;
        resetB     = 1'b0;
        run        = 1'b1;
        dbus       = 8'h00;
        zero       = 1'b0;
        repeat (3) tick();
        check_value("rst_ctrl", 32'(controlBits), 32'd0);
        check_value("rst_ir", 32'(ir), 32'd0);
        check_value("rst_icount", 32'(icount), 32'd0);
        check_value("rst_halted", 32'(halted), 32'd0);

        resetB = 1'b1;
        tick();
        check_value("first_fetch", 32'(controlBits), c_fetch_word);

        // Immediate load into A, then its operand byte on the bus
        check_value("fetch_word", 32'(controlBits), c_fetch_word);
        dbus = 8'h00;
        tick();
        check_value("imm_exec", 32'(controlBits), 32'h0841);
        dbus = 8'h5A;
        tick();
        exp_icount = 1;
        check_value("imm_icount", 32'(icount), 32'd1);

        run_instr(8'h3C, 1'b0);
        run_instr(8'hA0, 1'b0);
        run_instr(8'hA0, 1'b1);
        for (int i = 0; i < 252; i++)
            run_instr(rand_instr(), 1'($urandom));
        check_value("wrap_icount", 32'(icount), 32'd0);

        // Asynchronous reset in the middle of EXEC
        dbus = 8'h1F;
        tick();
        resetB = 1'b0;
        #1;
        check_value("async_ctrl", 32'(controlBits), 32'd0);
        check_value("async_icount", 32'(icount), 32'd0);
        check_value("async_ir", 32'(ir), 32'd0);
        #1;
        resetB = 1'b1;
        exp_icount = 0;
        tick();
        check_value("rel_fetch", 32'(controlBits), c_fetch_word);

`ifdef SEQUENCER_STALL_EN
        run_instr(8'h08, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("stall_ctrl", 32'(controlBits), 32'd0);
            check_value("stall_ir", 32'(ir), 32'h08);
            check_value("stall_icount", 32'(icount), 32'(exp_icount));
        end
        run = 1'b1;
        tick();
        check_value("stall_refetch", 32'(controlBits), c_fetch_word);
`endif

        for (int i = 0; i < 5; i++)
            run_instr(rand_instr(), 1'($urandom));
        run_instr(8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            dbus = 8'($urandom);
            zero = 1'($urandom);
            tick();
            check_value("halt_hold_ctrl", 32'(controlBits), 32'd0);
            check_value("halt_hold_flag", 32'(halted), 32'd1);
            check_value("halt_hold_icount", 32'(icount), 32'(exp_icount));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: resetB  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: dbus  in  8  data bus, sampled as instruction byte in FETCH.
REQ-004 SHALL have ports: zero  in  1  ALU zero flag, sampled for conditional jump.
REQ-005 SHALL have ports: controlBits  out  14  control word to register, ALU, memory and PC stages.
REQ-006 SHALL have ports: ir  out  8  current instruction register.
REQ-007 SHALL have ports: icount  out  8  retired-instruction counter.
REQ-008 SHALL have ports: halted  out  1  high once HALT is executed.

Function
REQ-009 SHALL use control bit positions [13] loadIR, [12] loadPC, [11] loadA, [10] loadB, [9] loadX, [8] loadQ, [7] loadM, [6] assertRom, [5] assertRam, [4] assertA, [3] assertX, [2] assertAlu, [1] doSub, [0] incPC, all active-high.
REQ-010 SHALL drive controlBits directly from flops: glitch-free, changing only just after a rising clk edge.
REQ-011 SHALL decode instruction fields: [7:5] dest (0 A, 1 B, 2 X, 3 Q, 4 PC, 5 PC-if-zero, 6 M, 7 HALT), [4:3] source (0 immediate, 1 A, 2 X, 3 ALU), [2] doSub, [1:0] ignored.
REQ-012 SHALL implement states FETCH, EXEC and HALT, with transitions FETCH->EXEC, EXEC->FETCH, and EXEC->HALT when dest=7.
REQ-013 SHALL output controlBits = loadIR|assertRom|incPC in FETCH; ir SHALL take dbus at the edge leaving FETCH.
REQ-014 SHALL output, in EXEC with source=immediate, assertRom|incPC plus the dest load bit.
REQ-015 SHALL output, in EXEC with source=A, X or ALU, the matching assert bit plus the dest load bit; doSub SHALL equal ir[2] only when source=ALU.
REQ-016 SHALL map dest=6 to loadM|assertRam=0 (write cycle).
REQ-017 SHALL map dest=5 to loadPC only if zero, sampled at the edge entering EXEC, is 1; otherwise no load, but an immediate operand SHALL still be consumed (incPC).
REQ-018 SHALL assert exactly one assert bit, or none, per cycle, so dbus has a single driver.
REQ-019 SHALL increment icount at each EXEC->FETCH or EXEC->HALT edge, wrapping 255->0.
REQ-020 SHALL hold controlBits=0 in HALT and keep halted=1 and icount frozen until reset.
REQ-021 SHALL take exactly 2 clk cycles per non-HALT instruction.

Reset
REQ-022 SHALL, while resetB=0, immediately force state=FETCH, ir=0, icount=0, halted=0 and controlBits=0.
REQ-023 SHALL output the FETCH control word in the first cycle after resetB rises.
REQ-024 SHALL abort any instruction in progress when reset occurs mid-instruction, with no partial load issued after reset.

Configuration
REQ-025 SHALL, when SEQUENCER_STALL_EN is defined, add input run (1 bit); with run=0 the state, ir and icount SHALL hold and controlBits SHALL be 0; with run=1 behaviour SHALL be as above.
REQ-026 SHALL, when SEQUENCER_STALL_EN is not defined, have no run port and behave as if run=1.

Structure
REQ-027 SHALL place the control bit index constants, control width (14), dest/source encodings and state enum in shared package control_pkg.
REQ-028 SHALL put the combinational IR-plus-state-to-next-control-word logic in sub-module instr_decode; control_sequencer SHALL hold all flops.

Verification
REQ-029 SHALL check reset: resetB=0 mid-EXEC -> controlBits=0, icount=0 at once; release -> next word 0x2041 (FETCH).
REQ-030 SHALL check immediate load: dbus=0x00 then 0x5A -> EXEC word 0x0841 (loadA|assertRom|incPC), 2 cycles per instruction, icount=1.
REQ-031 SHALL check ALU subtract: ir=0x3C (B<-ALU, sub) -> EXEC word 0x0406.
REQ-032 SHALL check the conditional jump: ir=0xA0 with zero=0 -> 0x0041 (no loadPC); with zero=1 -> 0x1041.
REQ-033 SHALL check HALT: ir=0xFF -> halted=1, controlBits=0 held 20 cycles, icount unchanged; and wrap: 256 instructions -> icount=0.
REQ-034 SHALL check, with SEQUENCER_STALL_EN, that run=0 for 5 cycles mid-FETCH -> controlBits=0 and state held; run=1 -> FETCH word is reissued.
